// File: rtl/c7bbiu_pkg.sv
// Shared AXI constants and helpers for the c7b bus interface unit.
package c7bbiu_pkg;

  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_EXOKAY      = 2'b01;
  localparam logic [1:0] RESP_SLVERR      = 2'b10;
  localparam logic [1:0] RESP_DECERR      = 2'b11;
  localparam logic [3:0] AX_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AX_PROT_DEFAULT  = 3'b000;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/c7bbiu_rd_xbar_if.sv
// AXI read channels (AR + R) between the BIU read crossbar and the external slave.
interface c7bbiu_rd_xbar_if #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int IDW = 4
);

  logic           ext_biu_ar_ready;
  logic           biu_ext_ar_valid;
  logic [IDW-1:0] biu_ext_ar_id;
  logic [AW-1:0]  biu_ext_ar_addr;
  logic [7:0]     biu_ext_ar_len;
  logic [2:0]     biu_ext_ar_size;
  logic [1:0]     biu_ext_ar_burst;
  logic           biu_ext_ar_lock;
  logic [3:0]     biu_ext_ar_cache;
  logic [2:0]     biu_ext_ar_prot;

  logic           biu_ext_r_ready;
  logic           ext_biu_r_valid;
  logic [IDW-1:0] ext_biu_r_id;
  logic [DW-1:0]  ext_biu_r_data;
  logic           ext_biu_r_last;
  logic [1:0]     ext_biu_r_resp;

  modport master (
    input  ext_biu_ar_ready,
    output biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, biu_ext_ar_len,
    output biu_ext_ar_size, biu_ext_ar_burst, biu_ext_ar_lock, biu_ext_ar_cache,
    output biu_ext_ar_prot,
    output biu_ext_r_ready,
    input  ext_biu_r_valid, ext_biu_r_id, ext_biu_r_data, ext_biu_r_last, ext_biu_r_resp
  );

  modport slave (
    output ext_biu_ar_ready,
    input  biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, biu_ext_ar_len,
    input  biu_ext_ar_size, biu_ext_ar_burst, biu_ext_ar_lock, biu_ext_ar_cache,
    input  biu_ext_ar_prot,
    input  biu_ext_r_ready,
    output ext_biu_r_valid, ext_biu_r_id, ext_biu_r_data, ext_biu_r_last, ext_biu_r_resp
  );

endinterface

// File: rtl/c7bbiu_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, with wrap-around.
module c7bbiu_rr_arb
  import c7bbiu_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? clog2(N) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                      = 1'b1;
        gnt[(int'(ptr) + k) % N]   = 1'b1;
        win                        = PW'((int'(ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= PW'((int'(win) + 1) % N);
    end
  end

endmodule

// File: rtl/c7bbiu_rd_xbar.sv
// Read-side crossbar: round-robin AR arbitration over NMST requesters, per-requester
// outstanding-burst tracking, R routing by AXI ID and cancel of in-flight bursts.
module c7bbiu_rd_xbar
  import c7bbiu_pkg::*;
#(
  parameter int NMST   = 3,
  parameter int AW     = 32,
  parameter int DW     = 64,
  parameter int IDW    = 4,
  parameter int MAXOUT = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NMST-1:0]    mst_req,
  input  logic [NMST*AW-1:0] mst_addr,
  input  logic [NMST*8-1:0]  mst_len,
  input  logic [NMST*3-1:0]  mst_size,
  input  logic [NMST-1:0]    mst_cancel,
  output logic [NMST-1:0]    mst_ack,
  output logic [NMST-1:0]    mst_rvalid,
  output logic [NMST-1:0]    mst_rlast,
  output logic [NMST-1:0]    mst_rerr,
  output logic [DW-1:0]      mst_rdata,
  c7bbiu_rd_xbar_if.master   axi
);

  localparam int OW = clog2(MAXOUT + 1);
  localparam int PW = (NMST > 1) ? clog2(NMST) : 1;

  logic            ar_valid_reg;
  logic [AW-1:0]   ar_addr_reg;
  logic [7:0]      ar_len_reg;
  logic [2:0]      ar_size_reg;
  logic            r_ready_reg;
  logic [OW-1:0]   outs_reg  [NMST];
  logic [OW-1:0]   cnl_reg   [NMST];
  logic [OW-1:0]   outs_next [NMST];
  logic [OW-1:0]   cnl_next  [NMST];

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   last_win;
  logic [IDW-1:0]  ar_id;
  logic [NMST-1:0] elig, gnt, ar_sel, r_sel, last_hit;
  logic            ar_hs, r_hs, ar_free, grant, r_err;
  logic [AW-1:0]   win_addr;
  logic [7:0]      win_len;
  logic [2:0]      win_size;

  assign ar_hs   = ar_valid_reg && axi.ext_biu_ar_ready;
  assign r_hs    = axi.ext_biu_r_valid && r_ready_reg;
  assign ar_free = !ar_valid_reg || axi.ext_biu_ar_ready;
  assign grant   = ar_free && (|elig);
  assign r_err   = (axi.ext_biu_r_resp == RESP_SLVERR) || (axi.ext_biu_r_resp == RESP_DECERR);

  // The pointer only moves on a grant and always sits one past the last winner,
  // so the presented AR id is recovered from it and holds under backpressure.
  assign last_win = (rr_ptr == '0) ? PW'(NMST - 1) : rr_ptr - 1'b1;
  assign ar_id    = ar_valid_reg ? IDW'(last_win) : '0;

  c7bbiu_rr_arb #(.N(NMST), .PW(PW)) u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     (elig),
    .advance (grant),
    .gnt     (gnt),
    .ptr     (rr_ptr)
  );

  generate
    for (genvar gi = 0; gi < NMST; gi++) begin : g_mst
      assign ar_sel[gi]   = ar_hs && (ar_id == IDW'(gi));
      assign r_sel[gi]    = r_hs && (axi.ext_biu_r_id == IDW'(gi));
      assign last_hit[gi] = r_sel[gi] && axi.ext_biu_r_last;
      // A request being acknowledged this cycle is still visible on mst_req;
      // it must not win a second time.
      assign elig[gi]     = mst_req[gi] && (outs_reg[gi] < OW'(MAXOUT)) && !ar_sel[gi];
      assign mst_ack[gi]  = ar_sel[gi];

      assign mst_rvalid[gi] = r_sel[gi] && (cnl_reg[gi] == '0);
      assign mst_rlast[gi]  = mst_rvalid[gi] && axi.ext_biu_r_last;
      assign mst_rerr[gi]   = mst_rvalid[gi] && r_err;

      // Stray r_last with nothing outstanding (e.g. after a reset) must not wrap.
      assign outs_next[gi] = (ar_sel[gi] && !last_hit[gi]) ? outs_reg[gi] + 1'b1 :
                             (!ar_sel[gi] && last_hit[gi] && (outs_reg[gi] != '0)) ?
                             outs_reg[gi] - 1'b1 : outs_reg[gi];
      assign cnl_next[gi]  = mst_cancel[gi] ? outs_next[gi] :
                             (last_hit[gi] && (cnl_reg[gi] != '0)) ? cnl_reg[gi] - 1'b1 :
                             cnl_reg[gi];
    end
  endgenerate

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    win_size = '0;
    for (int i = 0; i < NMST; i++) begin
      if (gnt[i]) begin
        win_addr = mst_addr[i*AW +: AW];
        win_len  = mst_len[i*8 +: 8];
        win_size = mst_size[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid_reg <= 1'b0;
      ar_addr_reg  <= '0;
      ar_len_reg   <= '0;
      ar_size_reg  <= '0;
      r_ready_reg  <= 1'b0;
    end else begin
      r_ready_reg <= 1'b1;
      if (grant) begin
        ar_valid_reg <= 1'b1;
        ar_addr_reg  <= win_addr;
        ar_len_reg   <= win_len;
        ar_size_reg  <= win_size;
      end else if (axi.ext_biu_ar_ready) begin
        ar_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NMST; i++) begin
        outs_reg[i] <= '0;
        cnl_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NMST; i++) begin
        outs_reg[i] <= outs_next[i];
        cnl_reg[i]  <= cnl_next[i];
      end
    end
  end

  assign axi.biu_ext_ar_valid = ar_valid_reg;
  assign axi.biu_ext_ar_id    = ar_id;
  assign axi.biu_ext_ar_addr  = ar_addr_reg;
  assign axi.biu_ext_ar_len   = ar_len_reg;
  assign axi.biu_ext_ar_size  = ar_size_reg;
  assign axi.biu_ext_ar_burst = BURST_INCR;
  assign axi.biu_ext_ar_lock  = 1'b0;
  assign axi.biu_ext_ar_cache = AX_CACHE_DEFAULT;
  assign axi.biu_ext_ar_prot  = AX_PROT_DEFAULT;
  assign axi.biu_ext_r_ready  = r_ready_reg;
  assign mst_rdata            = axi.ext_biu_r_data;

endmodule

// File: tb/tb_c7bbiu_rd_xbar.sv
// Self-checking bench for c7bbiu_rd_xbar: AR scoreboard, table-driven R routing, cancel and reset sequences.
module tb_c7bbiu_rd_xbar;
  import c7bbiu_pkg::*;

  localparam int NMST = 3, AW = 32, DW = 64, IDW = 4, MAXOUT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NMST-1:0]    mst_req, mst_cancel, mst_ack, mst_rvalid, mst_rlast, mst_rerr;
  logic [NMST*AW-1:0] mst_addr;
  logic [NMST*8-1:0]  mst_len;
  logic [NMST*3-1:0]  mst_size;
  logic [DW-1:0]      mst_rdata;

  c7bbiu_rd_xbar_if #(.AW(AW), .DW(DW), .IDW(IDW)) axi ();

  c7bbiu_rd_xbar #(.NMST(NMST), .AW(AW), .DW(DW), .IDW(IDW), .MAXOUT(MAXOUT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mst_req    (mst_req),
    .mst_addr   (mst_addr),
    .mst_len    (mst_len),
    .mst_size   (mst_size),
    .mst_cancel (mst_cancel),
    .mst_ack    (mst_ack),
    .mst_rvalid (mst_rvalid),
    .mst_rlast  (mst_rlast),
    .mst_rerr   (mst_rerr),
    .mst_rdata  (mst_rdata),
    .axi        (axi)
  );

  typedef struct {
    int         id;
    logic       last;
    logic [1:0] resp;
    logic [2:0] rv;
    logic [2:0] rl;
    logic [2:0] re;
  } rvec_t;

  int            total = 0;
  int            bad = 0;
  int            sb_id[$];
  rvec_t         r_sb[$];
  logic [AW-1:0] exp_addr [NMST];
  rvec_t         vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr();
    for (int i = 0; i < NMST; i++) mst_addr[i*AW +: AW] = exp_addr[i];
  endtask

  // AR scoreboard: every handshake must match the next expected requester.
  always @(negedge clk) begin
    if (resetn && axi.biu_ext_ar_valid && axi.ext_biu_ar_ready) begin
      if (sb_id.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ar_unexpected: got id %0d want no handshake", axi.biu_ext_ar_id);
      end else begin
        int e;
        e = sb_id.pop_front();
        chk("ar_id", 64'(axi.biu_ext_ar_id), 64'(e));
        chk("ar_ack", 64'(mst_ack), 64'(1 << e));
        chk("ar_addr", 64'(axi.biu_ext_ar_addr), 64'(exp_addr[e]));
      end
    end
  end

  // Drive one R beat at posedge+1, push expectation, compare at negedge, release.
  task automatic rbeat(input int id, input logic last, input logic [1:0] resp,
                       input logic [2:0] rv, input logic [2:0] rl, input logic [2:0] re);
    rvec_t v;
    logic [DW-1:0] d;
    d = {32'hDA7A_0000, 32'(id)};
    v.id = id; v.last = last; v.resp = resp; v.rv = rv; v.rl = rl; v.re = re;
    r_sb.push_back(v);
    axi.ext_biu_r_valid = 1'b1;
    axi.ext_biu_r_id    = IDW'(id);
    axi.ext_biu_r_last  = last;
    axi.ext_biu_r_resp  = resp;
    axi.ext_biu_r_data  = d;
    @(negedge clk);
    v = r_sb.pop_front();
    chk($sformatf("rvalid id%0d", v.id), 64'(mst_rvalid), 64'(v.rv));
    chk($sformatf("rlast id%0d", v.id), 64'(mst_rlast), 64'(v.rl));
    chk($sformatf("rerr id%0d", v.id), 64'(mst_rerr), 64'(v.re));
    chk("rdata", 64'(mst_rdata), 64'(d));
    step();
    axi.ext_biu_r_valid = 1'b0;
    axi.ext_biu_r_last  = 1'b0;
  endtask

  task automatic issue(input int id, input int n);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) sb_id.push_back(id);
    mst_req[id] = 1'b1;
    for (int c = 0; c < 20 && cnt < n; c++) begin
      @(negedge clk);
      if (mst_ack[id]) cnt++;
    end
    step();
    mst_req[id] = 1'b0;
    chk($sformatf("issue%0d_acks", id), 64'(cnt), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    mst_req = '0; mst_cancel = '0; mst_len = '0; mst_size = {NMST{3'd3}};
    axi.ext_biu_ar_ready = 1'b0; axi.ext_biu_r_valid = 1'b0; axi.ext_biu_r_id = '0;
    axi.ext_biu_r_data = '0; axi.ext_biu_r_last = 1'b0; axi.ext_biu_r_resp = '0;
    for (int i = 0; i < NMST; i++) exp_addr[i] = 32'h1000_0000 + 32'(i * 256);
    drive_addr();

    vecs[0]  = '{0, 1'b0, 2'b00, 3'b001, 3'b000, 3'b000};
    vecs[1]  = '{2, 1'b0, 2'b00, 3'b100, 3'b000, 3'b000};
    vecs[2]  = '{0, 1'b0, 2'b00, 3'b001, 3'b000, 3'b000};
    vecs[3]  = '{7, 1'b1, 2'b00, 3'b000, 3'b000, 3'b000};
    vecs[4]  = '{0, 1'b0, 2'b00, 3'b001, 3'b000, 3'b000};
    vecs[5]  = '{2, 1'b1, 2'b00, 3'b100, 3'b100, 3'b000};
    vecs[6]  = '{0, 1'b1, 2'b10, 3'b001, 3'b001, 3'b001};
    vecs[7]  = '{1, 1'b1, 2'b00, 3'b010, 3'b010, 3'b000};
    vecs[8]  = '{0, 1'b1, 2'b11, 3'b001, 3'b001, 3'b001};
    vecs[9]  = '{1, 1'b1, 2'b01, 3'b010, 3'b010, 3'b000};
    vecs[10] = '{2, 1'b1, 2'b00, 3'b100, 3'b100, 3'b000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_valid", 64'(axi.biu_ext_ar_valid), 64'd0);
    chk("rst_r_ready", 64'(axi.biu_ext_r_ready), 64'd0);
    chk("rst_ar_addr", 64'(axi.biu_ext_ar_addr), 64'd0);
    chk("rst_ack", 64'(mst_ack), 64'd0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("r_ready_before_edge", 64'(axi.biu_ext_r_ready), 64'd0);
    step();
    chk("r_ready_after_edge", 64'(axi.biu_ext_r_ready), 64'd1);

    // Round-robin under constant traffic, each requester saturates at MAXOUT
    for (int k = 0; k < 6; k++) sb_id.push_back(k % NMST);
    axi.ext_biu_ar_ready = 1'b1;
    mst_req = '1;
    repeat (10) step();
    mst_req = '0;
    chk("rr_sb_empty", 64'(sb_id.size()), 64'd0);
    for (int i = 0; i < NMST; i++) chk($sformatf("rr_outs%0d", i), 64'(dut.outs_reg[i]), 64'(MAXOUT));

    // Interleaved R, error response and unknown id, table-driven
    for (int k = 0; k < 11; k++)
      rbeat(vecs[k].id, vecs[k].last, vecs[k].resp, vecs[k].rv, vecs[k].rl, vecs[k].re);
    for (int i = 0; i < NMST; i++) chk($sformatf("r_outs%0d", i), 64'(dut.outs_reg[i]), 64'd0);

    // AR backpressure
    axi.ext_biu_ar_ready = 1'b0;
    exp_addr[1] = 32'h1000_0040;
    drive_addr();
    mst_len[8 +: 8] = 8'd3;
    sb_id.push_back(1);
    mst_req = 3'b010;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(axi.biu_ext_ar_valid), 64'd1);
      chk("bp_addr", 64'(axi.biu_ext_ar_addr), 64'h1000_0040);
      chk("bp_id", 64'(axi.biu_ext_ar_id), 64'd1);
      chk("bp_ack", 64'(mst_ack), 64'd0);
      step();
    end
    chk("bp_len", 64'(axi.biu_ext_ar_len), 64'd3);
    chk("bp_burst", 64'(axi.biu_ext_ar_burst), 64'(BURST_INCR));
    chk("bp_cache", 64'(axi.biu_ext_ar_cache), 64'h3);
    axi.ext_biu_ar_ready = 1'b1;
    @(negedge clk);
    step();
    mst_req = '0;
    @(negedge clk);
    chk("bp_valid_drop", 64'(axi.biu_ext_ar_valid), 64'd0);
    step();
    rbeat(1, 1'b1, 2'b00, 3'b010, 3'b010, 3'b000);

    // Cancel with two outstanding; the same-cycle beat is still delivered
    issue(0, 2);
    chk("cnl_outs0", 64'(dut.outs_reg[0]), 64'd2);
    mst_cancel = 3'b001;
    rbeat(0, 1'b0, 2'b00, 3'b001, 3'b000, 3'b000);
    mst_cancel = '0;
    rbeat(0, 1'b0, 2'b00, 3'b000, 3'b000, 3'b000);
    rbeat(0, 1'b1, 2'b00, 3'b000, 3'b000, 3'b000);
    rbeat(0, 1'b0, 2'b00, 3'b000, 3'b000, 3'b000);
    rbeat(0, 1'b1, 2'b10, 3'b000, 3'b000, 3'b000);
    chk("cnl0_done", 64'(dut.cnl_reg[0]), 64'd0);
    chk("cnl_outs0_done", 64'(dut.outs_reg[0]), 64'd0);
    issue(0, 1);
    rbeat(0, 1'b1, 2'b00, 3'b001, 3'b001, 3'b000);

    // Cancel coinciding with AR handshake
    axi.ext_biu_ar_ready = 1'b0;
    sb_id.push_back(0);
    mst_req = 3'b001;
    step();
    @(negedge clk);
    chk("cah_valid", 64'(axi.biu_ext_ar_valid), 64'd1);
    step();
    axi.ext_biu_ar_ready = 1'b1;
    mst_cancel = 3'b001;
    @(negedge clk);
    step();
    mst_cancel = '0;
    mst_req = '0;
    @(negedge clk);
    chk("cah_cnl0", 64'(dut.cnl_reg[0]), 64'd1);
    chk("cah_outs0", 64'(dut.outs_reg[0]), 64'd1);
    step();
    rbeat(0, 1'b1, 2'b00, 3'b000, 3'b000, 3'b000);
    chk("cah_cnl0_done", 64'(dut.cnl_reg[0]), 64'd0);

    // Cancel with nothing outstanding leaves the requester unsuppressed
    mst_cancel = 3'b100;
    step();
    mst_cancel = '0;
    chk("cnl2_zero", 64'(dut.cnl_reg[2]), 64'd0);
    rbeat(2, 1'b1, 2'b00, 3'b100, 3'b100, 3'b000);

    // Async reset mid-operation
    issue(1, 1);
    axi.ext_biu_ar_ready = 1'b0;
    sb_id.push_back(2);
    mst_req = 3'b100;
    step();
    @(negedge clk);
    chk("ar_before_rst", 64'(axi.biu_ext_ar_valid), 64'd1);
    #2;
    resetn = 1'b0;
    sb_id.delete();
    #1;
    chk("rst_mid_ar_valid", 64'(axi.biu_ext_ar_valid), 64'd0);
    chk("rst_mid_r_ready", 64'(axi.biu_ext_r_ready), 64'd0);
    chk("rst_mid_outs1", 64'(dut.outs_reg[1]), 64'd0);
    mst_req = '0;
    step();
    resetn = 1'b1;
    step();
    chk("rst_mid_r_ready_up", 64'(axi.biu_ext_r_ready), 64'd1);
    chk("rst_mid_ar_idle", 64'(axi.biu_ext_ar_valid), 64'd0);
    rbeat(1, 1'b1, 2'b00, 3'b010, 3'b010, 3'b000);
    chk("rst_stray_outs1", 64'(dut.outs_reg[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
